// File: rtl/audio_pkg.sv
// Shared audio-path definitions used by the I2S receiver and the DAC interface.
// Sample width, channel encoding on LRCK and the word-tracking state enum.
package audio_pkg;

  localparam int I2S_WORD_W = 24;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_t;

endpackage

// File: rtl/sync2ff.sv
// Two-flop synchroniser for a single asynchronous pin into the clk domain.
module sync2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i2s_rx.sv
// Clock-slave I2S receiver: deserialises left/right words from the ADC pins and
// hands left-justified stereo pairs to the consumer with sticky error flags.
import audio_pkg::*;

module i2s_rx #(
  parameter int WORD_W   = I2S_WORD_W,
  parameter int MIN_BITS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              i2s_bck,
  input  logic              i2s_lrck,
  input  logic              i2s_data,
  input  logic              sample_ack,
  input  logic              clear_status,
  output logic [WORD_W-1:0] left_data,
  output logic [WORD_W-1:0] right_data,
  output logic              sample_valid,
  output logic              overrun,
  output logic              frame_error,
  output i2s_state_t        state
);

  logic bck_s, lrck_s, data_s, bck_d;

  sync2ff u_sync_bck  (.clk(clk), .rst(rst), .d(i2s_bck),  .q(bck_s));
  sync2ff u_sync_lrck (.clk(clk), .rst(rst), .d(i2s_lrck), .q(lrck_s));
  sync2ff u_sync_data (.clk(clk), .rst(rst), .d(i2s_data), .q(data_s));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bck_d <= 1'b0;
    else      bck_d <= bck_s;
  end

  logic bck_rise;
  assign bck_rise = bck_s & ~bck_d;

  logic              lrck_prev;
  logic [4:0]        bitcnt;
  logic [WORD_W-1:0] sh_l, sh_r, left_hold;

  // Word-end datapath: the bit on the LRCK-changing edge is the LSB of the old word.
  logic [4:0]        cnt_next;
  logic              word_end, short_word;
  logic [WORD_W-1:0] ch_shreg, shin, word_final;
  logic [5:0]        word_bits, shamt;

  always_comb begin
    cnt_next   = (bitcnt == 5'd31) ? 5'd31 : bitcnt + 5'd1;
    word_end   = bck_rise && (lrck_s != lrck_prev);
    short_word = {1'b0, cnt_next} < 6'(MIN_BITS);
    ch_shreg   = (lrck_prev == CH_RIGHT) ? sh_r : sh_l;
    shin       = ({1'b0, bitcnt} < 6'(WORD_W)) ? {ch_shreg[WORD_W-2:0], data_s} : ch_shreg;
    word_bits  = ({1'b0, cnt_next} > 6'(WORD_W)) ? 6'(WORD_W) : {1'b0, cnt_next};
    shamt      = 6'(WORD_W) - word_bits;
    word_final = shin << shamt;
  end

  i2s_state_t state_next;
  logic       capture, load_left, pair_done, ferr_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SYNC;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    load_left  = 1'b0;
    pair_done  = 1'b0;
    ferr_set   = 1'b0;
    if (!enable) begin
      state_next = SYNC;
    end else if (bck_rise) begin
      case (state)
        SYNC: begin
          if (lrck_prev == CH_RIGHT && lrck_s == CH_LEFT) state_next = LEFT;
        end
        LEFT, RIGHT: begin
          capture = 1'b1;
          if (word_end) begin
            if (short_word) begin
              ferr_set   = 1'b1;
              state_next = SYNC;
            end else if (state == LEFT) begin
              load_left  = 1'b1;
              state_next = RIGHT;
            end else begin
              pair_done  = 1'b1;
              state_next = LEFT;
            end
          end
        end
        default: state_next = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lrck_prev <= CH_LEFT;
      bitcnt    <= '0;
      sh_l      <= '0;
      sh_r      <= '0;
      left_hold <= '0;
    end else begin
      if (bck_rise) lrck_prev <= lrck_s;
      if (!enable || state == SYNC) begin
        bitcnt <= '0;
        sh_l   <= '0;
        sh_r   <= '0;
      end else if (capture) begin
        if (word_end) begin
          bitcnt <= '0;
          sh_l   <= '0;
          sh_r   <= '0;
        end else begin
          bitcnt <= cnt_next;
          if (lrck_prev == CH_RIGHT) sh_r <= shin;
          else                       sh_l <= shin;
        end
      end
      if (load_left) left_hold <= word_final;
    end
  end

  // Handshake: a pair is offered while sample_valid=1 and data holds still; it is
  // consumed at any clk edge where sample_ack=1, and a pair completing on that same
  // edge replaces it directly. Ack with nothing pending has no effect.
  logic ovr_set;
  assign ovr_set = pair_done && sample_valid && !sample_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      if (pair_done && (!sample_valid || sample_ack)) begin
        left_data    <= left_hold;
        right_data   <= word_final;
        sample_valid <= 1'b1;
      end else if (sample_ack) begin
        sample_valid <= 1'b0;
      end
      overrun     <= (overrun && !clear_status) || ovr_set;
      frame_error <= (frame_error && !clear_status) || ferr_set;
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: a table of stereo frames with hand-computed expected
// pairs, plus sequences for mid-word start, overrun, ack/completion, disable and reset.
import audio_pkg::*;

module tb_i2s_rx;

  localparam int W = 24;

  logic         clk, rst, enable;
  logic         i2s_bck, i2s_lrck, i2s_data;
  logic         sample_ack, clear_status;
  logic [W-1:0] left_data, right_data;
  logic         sample_valid, overrun, frame_error;
  i2s_state_t   state;

  i2s_rx #(.WORD_W(W), .MIN_BITS(16)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .i2s_bck(i2s_bck), .i2s_lrck(i2s_lrck), .i2s_data(i2s_data),
    .sample_ack(sample_ack), .clear_status(clear_status),
    .left_data(left_data), .right_data(right_data),
    .sample_valid(sample_valid), .overrun(overrun), .frame_error(frame_error),
    .state(state)
  );

  // 25 MHz system clock
  initial clk = 1'b0;
  always #20 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  logic [2*W-1:0] exp_q[$];

  typedef struct {
    logic [31:0]  l;
    logic [31:0]  r;
    int           n;
    int           slot;
    logic [W-1:0] el;
    logic [W-1:0] er;
    logic         ev;
    logic         ef;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic slot_bit(input logic [31:0] w, input int n, input int j);
    return (j < n) ? w[n-1-j] : 1'b0;
  endfunction

  // One BCK period: pins change with BCK low, data sampled on the rising edge.
  // ack_pulse raises sample_ack exactly on the clk edge that acts on this rise.
  task automatic send_bit(input logic l, input logic d, input logic ack_pulse);
    i2s_bck  = 1'b0;
    i2s_lrck = l;
    i2s_data = d;
    repeat (4) @(negedge clk);
    i2s_bck = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (ack_pulse) sample_ack = 1'b1;
    @(negedge clk);
    sample_ack = 1'b0;
    @(negedge clk);
  endtask

  // Frame whose leading (LRCK-falling) bit was already sent; ends with the next lead bit.
  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n,
                            input int slot, input logic ack_pulse);
    for (int j = 1; j < slot; j++) send_bit(1'b0, slot_bit(l, n, j-1), 1'b0);
    send_bit(1'b1, slot_bit(l, n, slot-1), 1'b0);
    for (int j = 1; j < slot; j++) send_bit(1'b1, slot_bit(r, n, j-1), 1'b0);
    send_bit(1'b0, slot_bit(r, n, slot-1), ack_pulse);
  endtask

  task automatic resync();
    for (int j = 0; j < 4; j++) send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_ack();
    sample_ack = 1'b1;
    @(negedge clk);
    sample_ack = 1'b0;
    check("valid_after_ack", 32'(sample_valid), 32'd0);
  endtask

  task automatic do_clear();
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2*W-1:0] exp_pair;

    vecs[0] = '{32'h00123456, 32'h00ABCDEF, 24, 32, 24'h123456, 24'hABCDEF, 1'b1, 1'b0};
    vecs[1] = '{32'h00008001, 32'h00007FFE, 16, 16, 24'h800100, 24'h7FFE00, 1'b1, 1'b0};
    vecs[2] = '{32'h00FFFFFF, 32'h00000001, 24, 24, 24'hFFFFFF, 24'h000001, 1'b1, 1'b0};
    vecs[3] = '{32'hDEADBEEF, 32'h01234567, 32, 32, 24'hDEADBE, 24'h012345, 1'b1, 1'b0};
    vecs[4] = '{32'h0002ABCD, 32'h0003FFFF, 18, 18, 24'hAAF340, 24'hFFFFC0, 1'b1, 1'b0};
    vecs[5] = '{32'h000005A5, 32'h00000123, 12, 12, 24'h000000, 24'h000000, 1'b0, 1'b1};
    vecs[6] = '{32'h0000A5A5, 32'h00001234, 16, 16, 24'hA5A500, 24'h123400, 1'b1, 1'b0};
    vecs[7] = '{32'h00007FFF, 32'h00000001, 15, 15, 24'h000000, 24'h000000, 1'b0, 1'b1};
    vecs[8] = '{32'h00800000, 32'h00000000, 24, 32, 24'h800000, 24'h000000, 1'b1, 1'b0};

    rst = 1'b0; enable = 1'b1;
    i2s_bck = 1'b0; i2s_lrck = 1'b0; i2s_data = 1'b0;
    sample_ack = 1'b0; clear_status = 1'b0;
    @(negedge clk);

    check("rst_left", 32'(left_data), 32'd0);
    check("rst_right", 32'(right_data), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_ferr", 32'(frame_error), 32'd0);
    check("rst_state", 32'(state), 32'(SYNC));

    // Reset released mid-left-word, then a partial right word: all of it discarded
    for (int j = 0; j < 3; j++) send_bit(1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    for (int j = 0; j < 5; j++) send_bit(1'b0, 1'b1, 1'b0);
    for (int j = 0; j < 6; j++) send_bit(1'b1, 1'b1, 1'b0);
    check("midword_valid", 32'(sample_valid), 32'd0);
    check("midword_ferr", 32'(frame_error), 32'd0);
    send_bit(1'b0, 1'b1, 1'b0);
    check("midword_state", 32'(state), 32'(LEFT));

    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i].l, vecs[i].r, vecs[i].n, vecs[i].slot, 1'b0);
      check($sformatf("v%0d_valid", i), 32'(sample_valid), 32'(vecs[i].ev));
      check($sformatf("v%0d_ferr", i), 32'(frame_error), 32'(vecs[i].ef));
      check($sformatf("v%0d_overrun", i), 32'(overrun), 32'd0);
      if (vecs[i].ev) begin
        exp_q.push_back({vecs[i].el, vecs[i].er});
        exp_pair = exp_q.pop_front();
        check($sformatf("v%0d_left", i), 32'(left_data), 32'(exp_pair[2*W-1:W]));
        check($sformatf("v%0d_right", i), 32'(right_data), 32'(exp_pair[W-1:0]));
        do_ack();
      end
      if (vecs[i].ef) begin
        do_clear();
        check($sformatf("v%0d_ferr_clear", i), 32'(frame_error), 32'd0);
      end
    end

    // Overrun: second pair dropped, first retained
    send_frame(32'h111111, 32'h222222, 24, 24, 1'b0);
    check("ovr_first_valid", 32'(sample_valid), 32'd1);
    send_frame(32'h333333, 32'h444444, 24, 24, 1'b0);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_left", 32'(left_data), 32'h111111);
    check("ovr_right", 32'(right_data), 32'h222222);
    check("ovr_valid", 32'(sample_valid), 32'd1);
    do_clear();
    check("ovr_clear", 32'(overrun), 32'd0);
    do_ack();

    // Ack on the same edge the next pair completes
    send_frame(32'h0A0B0C, 32'h0D0E0F, 24, 24, 1'b0);
    check("sim_first_valid", 32'(sample_valid), 32'd1);
    send_frame(32'h102030, 32'h405060, 24, 24, 1'b1);
    check("sim_left", 32'(left_data), 32'h102030);
    check("sim_right", 32'(right_data), 32'h405060);
    check("sim_valid", 32'(sample_valid), 32'd1);
    check("sim_overrun", 32'(overrun), 32'd0);
    do_ack();

    // Disable mid-word keeps the pending pair
    send_frame(32'hC0FFEE, 32'hBADCAF, 24, 24, 1'b0);
    for (int j = 0; j < 5; j++) send_bit(1'b0, 1'b1, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    check("dis_state", 32'(state), 32'(SYNC));
    check("dis_valid", 32'(sample_valid), 32'd1);
    check("dis_left", 32'(left_data), 32'hC0FFEE);
    check("dis_right", 32'(right_data), 32'hBADCAF);
    enable = 1'b1;
    do_ack();
    resync();

    // Asynchronous reset during a right word
    send_frame(32'h13579B, 32'h2468AC, 24, 24, 1'b0);
    check("prerst_valid", 32'(sample_valid), 32'd1);
    for (int j = 0; j < 24; j++) send_bit(1'b0, 1'b1, 1'b0);
    for (int j = 0; j < 5; j++) send_bit(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    #2;
    check("arst_left", 32'(left_data), 32'd0);
    check("arst_right", 32'(right_data), 32'd0);
    check("arst_valid", 32'(sample_valid), 32'd0);
    check("arst_state", 32'(state), 32'(SYNC));
    @(negedge clk);
    rst = 1'b1;
    resync();
    send_frame(32'h00FACE, 32'h00BEEF, 16, 16, 1'b0);
    check("post_rst_valid", 32'(sample_valid), 32'd1);
    check("post_rst_left", 32'(left_data), 32'hFACE00);
    check("post_rst_right", 32'(right_data), 32'hBEEF00);
    check("post_rst_ferr", 32'(frame_error), 32'd0);
    do_ack();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
